divmod: RTL
===========

# divmod

Parametrised sequential integer divider producing quotient and remainder together, unsigned or signed (truncating) per operation. It generalises the team's remainder-only modulo unit and sits in the primality datapath wherever both quotient and remainder of a trial division are needed. Start is edge-triggered by `go`, and results are held until the next operation. Each operation takes a data-dependent latency of a few cycles plus one cycle per quotient bit.

## Interface
- `WIDTH`, default 16: operand and result width; minimum 2.
- `SW`, default `$clog2(WIDTH)`: shift-counter width; derived, do not override.
- `clk`  in  1  single clock; all state updates on its rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `go`  in  1  start request; only a 0→1 edge, detected against a registered copy, starts an operation.
- `sgn`  in  1  sampled with `go`; 1 selects two's-complement signed division, 0 selects unsigned.
- `a`  in  WIDTH  dividend, sampled on the `go` edge only.
- `b`  in  WIDTH  divisor, sampled on the `go` edge only.
- `ready`  out  1  high when idle, including after an error.
- `error`  out  1  high when the last operation was rejected.
- `quot`  out  WIDTH  quotient of the last successful operation.
- `rem`  out  WIDTH  remainder of the last successful operation.

## Operation
- States: READY, NORM, ITER, FIX, ERROR.
- **Edge capture** (any state), on a `go` edge:
  - If `b==0`, or if `sgn=1`, `a==MIN` and `b==-1`: go to ERROR.
  - Otherwise store |a|, |b| (unsigned when `sgn=0`), `sgn`, and the sign flags; go to NORM.
  - |MIN| = 2^(WIDTH-1) fits unsigned in WIDTH bits.
- **NORM**: s = msb(A) > msb(B) ? msb(A) − msb(B) : 0, where msb is the index of the highest set bit and msb(0)=0. Set B ← B<<s, cnt ← s, Q ← 0; go to ITER.
- **ITER**, one step per cycle:
  - t = (B ≤ A); Q ← {Q[WIDTH-2:0], t}; A ← t ? A−B : A; B ← B>>1.
  - If cnt==0, go to FIX; otherwise cnt ← cnt−1.
  - Exactly s+1 steps.
- **FIX**:
  - `quot` ← (sgn && sa≠sb) ? −Q : Q.
  - `rem` ← (sgn && sa) ? −A : A.
  - Go to READY.
  - Signed results are C-style: the quotient truncates toward zero and the remainder takes the dividend's sign.
- **ERROR / READY**: hold until the next `go` edge. `quot` and `rem` are not modified by an error.
- A `go` edge while busy aborts the current operation and restarts with the new operands. No partial results are written.
- `go` held high produces one operation only. A `go` already high in the first cycle after reset counts as an edge.

## Timing
- Reset values: `ready`=1, `error`=0, `quot`=0, `rem`=0, state READY, registered `go` = 0.
- Reset mid-operation abandons it; the reset values hold from the next edge.
- Call the capturing clock edge E0. Then:
  - `ready` falls at E0.
  - NORM runs at E1.
  - ITER runs at E2…E(s+2).
  - FIX at E(s+3) writes `quot`/`rem` and raises `ready`.
  - Latency is s+3 cycles; worst case WIDTH+2.
- Error path: at E0, `ready`=1 and `error`=1. `error` clears at the next accepted `go` edge.
- `ready` and `error` are registered and derived from the next state. `quot` and `rem` change only at FIX edges.

## Structure
- Shared defines header `divmod_defs`: state encodings (3 bits) and the assertion macro.
- The assertion macro checks cnt==0 on the ITER→FIX transition.
- Sub-module `msb_index` (WIDTH, SW): combinational priority encoder, instantiated twice for A and B.
- Subtract, compare and negation stay in the top level.

## Test plan
- Unsigned 100 / 7, `sgn`=0: s=4; ready rises 7 cycles after E0; `quot`=14, `rem`=2, `error`=0.
- Signed −7 / 2 (0xFFF9, 0x0002): `quot`=0xFFFD (−3), `rem`=0xFFFF (−1). Also 7 / −2 gives `quot`=0xFFFD, `rem`=0x0001.
- Unsigned 3 / 10: s=0, latency 3, `quot`=0, `rem`=3. Also 0xFFFF / 1: s=15, latency 18, `quot`=0xFFFF, `rem`=0.
- Errors:
  - 5 / 0 gives `ready`=1 and `error`=1 at E0, with `quot`/`rem` unchanged from the prior result.
  - Signed 0x8000 / 0xFFFF gives `error`=1.
  - A following valid op clears `error`.
- Restart and hold: start 1000 / 3, then issue a new `go` edge for 50 / 6 two cycles later; the only result is `quot`=8, `rem`=2. `go` held high for 30 cycles yields one operation.
- Reset: assert `rst` mid-ITER; next cycle `ready`=1, `error`=0, `quot`=`rem`=0, and no late result appears.

Source files
------------

// File: rtl/divmod_pkg.sv
// Shared types for the divmod sequential divider.
package divmod_pkg;

  typedef enum logic [2:0] {
    ST_READY = 3'd0,
    ST_NORM  = 3'd1,
    ST_ITER  = 3'd2,
    ST_FIX   = 3'd3,
    ST_ERROR = 3'd4
  } state_t;

endpackage

// File: rtl/divmod_msb_index.sv
// Combinational priority encoder: index of the highest set bit, 0 for an all-zero input.
module msb_index #(
  parameter int WIDTH = 16,
  parameter int SW    = $clog2(WIDTH)
) (
  input  logic [WIDTH-1:0] i_x,
  output logic [SW-1:0]    o_idx
);

  always_comb begin
    o_idx = '0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      if (i_x[i]) o_idx = SW'(i);
    end
  end

endmodule

// File: rtl/divmod.sv
// Sequential restoring divider producing quotient and remainder, unsigned or
// truncating signed; go is edge-triggered and results hold until the next op.
module divmod
  import divmod_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int SW    = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             go,
  input  logic             sgn,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             ready,
  output logic             error,
  output logic [WIDTH-1:0] quot,
  output logic [WIDTH-1:0] rem
);

  state_t           r_state, w_next;
  logic             r_go_d;
  logic [WIDTH-1:0] r_A, r_B, r_Q;
  logic [SW-1:0]    r_cnt;
  logic             r_sgn, r_sa, r_sb;
  logic             r_ready, r_error;
  logic [WIDTH-1:0] r_quot, r_rem;

  logic             w_edge, w_reject, w_take;
  logic [WIDTH-1:0] w_min, w_abs_a, w_abs_b, w_diff;
  logic [SW-1:0]    w_msb_a, w_msb_b, w_shift;

  assign w_edge   = go & ~r_go_d;
  assign w_min    = {1'b1, {(WIDTH-1){1'b0}}};
  assign w_reject = (b == '0) || (sgn && (a == w_min) && (b == '1));
  // |MIN| wraps to MIN, which is the correct unsigned magnitude.
  assign w_abs_a  = (sgn && a[WIDTH-1]) ? -a : a;
  assign w_abs_b  = (sgn && b[WIDTH-1]) ? -b : b;

  msb_index #(.WIDTH(WIDTH), .SW(SW)) u_msb_a (.i_x(r_A), .o_idx(w_msb_a));
  msb_index #(.WIDTH(WIDTH), .SW(SW)) u_msb_b (.i_x(r_B), .o_idx(w_msb_b));

  assign w_shift = (w_msb_a > w_msb_b) ? (w_msb_a - w_msb_b) : '0;
  assign w_take  = (r_B <= r_A);
  assign w_diff  = r_A - r_B;

  always_comb begin
    w_next = r_state;
    if (w_edge) begin
      w_next = w_reject ? ST_ERROR : ST_NORM;
    end else begin
      case (r_state)
        ST_NORM: w_next = ST_ITER;
        ST_ITER: if (r_cnt == '0) w_next = ST_FIX;
        ST_FIX:  w_next = ST_READY;
        default: w_next = r_state;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_READY;
      r_go_d  <= 1'b0;
      r_ready <= 1'b1;
      r_error <= 1'b0;
      r_quot  <= '0;
      r_rem   <= '0;
    end else begin
      r_state <= w_next;
      r_go_d  <= go;
      r_ready <= (w_next == ST_READY) || (w_next == ST_ERROR);
      r_error <= (w_next == ST_ERROR);
      if (!w_edge && r_state == ST_FIX) begin
        r_quot <= (r_sgn && (r_sa != r_sb)) ? -r_Q : r_Q;
        r_rem  <= (r_sgn && r_sa) ? -r_A : r_A;
      end
    end
  end

  // Datapath registers need no reset: they are always loaded before use.
  always_ff @(posedge clk) begin
    if (w_edge) begin
      r_A   <= w_abs_a;
      r_B   <= w_abs_b;
      r_sgn <= sgn;
      r_sa  <= a[WIDTH-1];
      r_sb  <= b[WIDTH-1];
    end else begin
      case (r_state)
        ST_NORM: begin
          r_B   <= r_B << w_shift;
          r_cnt <= w_shift;
          r_Q   <= '0;
        end
        ST_ITER: begin
          r_Q <= {r_Q[WIDTH-2:0], w_take};
          if (w_take) r_A <= w_diff;
          r_B <= r_B >> 1;
          if (r_cnt != '0) r_cnt <= r_cnt - 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && r_state == ST_ITER && w_next == ST_FIX) begin
      assert (r_cnt == '0);
    end
  end

  assign ready = r_ready;
  assign error = r_error;
  assign quot  = r_quot;
  assign rem   = r_rem;

endmodule
